// File: rtl/dti_pack.sv
// dti_pack: shared types, field positions and helpers for the DTI
// connect/disconnect responder. The optional error-reporting ports
// (err_pulse, err_cnt) are enabled with the DTI_CONDIS_ERR_EN macro.
package dti_pack;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int TBU_NUM_WIDTH   = 6;

  // Message field positions, shared by request and ack.
  localparam int MSG_TYPE_LSB = 0;
  localparam int MSG_TYPE_W   = 4;
  localparam int STATE_BIT    = 4;
  localparam int TBU_ID_LSB   = 8;
  localparam int TOK_LSB      = 16;
  localparam int TOK_W        = 8;

  typedef enum logic [1:0] {
    ENTRY_IDLE         = 2'd0,
    ENTRY_CONNECTED    = 2'd1,
    ENTRY_TRANSACTION  = 2'd2,
    ENTRY_DISCONNECTED = 2'd3
  } entry_state_t;

  typedef enum logic [3:0] {
    DTI_TBU_CONDIS_REQ = 4'h0
  } s_msg_type_t;

  typedef enum logic [3:0] {
    DTI_TBU_CONDIS_ACK = 4'h0
  } m_msg_type_t;

  // Build an ack word; every bit outside the named fields is zero.
  function automatic logic [AXIS_DATA_WIDTH-1:0] make_ack(
    input logic                     st,
    input logic [TBU_NUM_WIDTH-1:0] id,
    input logic [TOK_W-1:0]         gnt
  );
    logic [AXIS_DATA_WIDTH-1:0] d;
    d                              = '0;
    d[MSG_TYPE_LSB +: MSG_TYPE_W]  = DTI_TBU_CONDIS_ACK;
    d[STATE_BIT]                   = st;
    d[TBU_ID_LSB +: TBU_NUM_WIDTH] = id;
    d[TOK_LSB +: TOK_W]            = gnt;
    return d;
  endfunction

endpackage

// File: rtl/dti_condis_entry.sv
// dti_condis_entry: connection state of a single TBU. Connect and
// disconnect completion are driven by the responder's ack handshake;
// CONNECTED/TRANSACTION follow the TBU's busy flag every cycle.
module dti_condis_entry
  import dti_pack::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_busy,
  input  logic         i_disconnect,
  input  logic         i_ack_connect,
  input  logic         i_ack_disconnect,
  output entry_state_t o_state,
  output logic         o_connected
);

  entry_state_t r_state;

  // Per-entry state machine; disconnect wins over busy tracking.
  // NOTE: state registers use non-blocking assignments and an async
  // active-low reset so every flop updates together on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTRY_IDLE;
    end else begin
      case (r_state)
        ENTRY_IDLE: begin
          if (i_ack_connect) r_state <= ENTRY_CONNECTED;
        end
        ENTRY_CONNECTED: begin
          if (i_disconnect) r_state <= ENTRY_DISCONNECTED;
          else if (i_busy)  r_state <= ENTRY_TRANSACTION;
        end
        ENTRY_TRANSACTION: begin
          if (i_disconnect) r_state <= ENTRY_DISCONNECTED;
          else if (!i_busy) r_state <= ENTRY_CONNECTED;
        end
        ENTRY_DISCONNECTED: begin
          if (i_ack_disconnect) r_state <= ENTRY_IDLE;
        end
        default: r_state <= ENTRY_IDLE;
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_connected = (r_state == ENTRY_CONNECTED) ||
                       (r_state == ENTRY_TRANSACTION);

endmodule

// File: rtl/dti_condis_responder.sv
// dti_condis_responder: accepts DTI TBU connect/disconnect requests one at
// a time, tracks per-TBU connection state and returns acks. Define
// DTI_CONDIS_ERR_EN to add err_pulse / err_cnt reporting of illegal requests.
module dti_condis_responder
  import dti_pack::*;
#(
  parameter int TBU_NUM     = 2,
  parameter int TOK_GNT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  input  logic [TBU_NUM-1:0]         tbu_busy,
  output logic [TBU_NUM-1:0]         tbu_connected
`ifdef DTI_CONDIS_ERR_EN
  ,
  output logic                       err_pulse,
  output logic [7:0]                 err_cnt
`endif
);

  localparam logic [TBU_NUM_WIDTH:0] ID_LIMIT = (TBU_NUM_WIDTH + 1)'(TBU_NUM);
  localparam logic [TOK_W-1:0]       GNT_MAX  = TOK_W'(TOK_GNT_MAX);

  logic                       r_pending;
  logic                       r_pend_disc;
  logic                       r_pend_grant;
  logic [TBU_NUM_WIDTH-1:0]   r_pend_id;
  logic                       r_mvalid;
  logic [AXIS_DATA_WIDTH-1:0] r_mdata;

  entry_state_t w_state [TBU_NUM];
  entry_state_t w_req_state;
  entry_state_t w_pend_state;
  logic         w_pend_busy;

  // Request decode.
  logic [MSG_TYPE_W-1:0]    w_msg_type;
  logic                     w_req_conn;
  logic [TBU_NUM_WIDTH-1:0] w_req_id;
  logic [TOK_W-1:0]         w_tok_req;
  logic [TOK_W-1:0]         w_tok_gnt;
  logic                     w_grant;
  logic                     w_id_ok;
  logic                     w_legal;
  logic                     w_accept;
  logic                     w_ack_hs;
  logic                     w_unused_bits;

  assign w_msg_type = s_axis_tdata[MSG_TYPE_LSB +: MSG_TYPE_W];
  assign w_req_conn = s_axis_tdata[STATE_BIT];
  assign w_req_id   = s_axis_tdata[TBU_ID_LSB +: TBU_NUM_WIDTH];
  assign w_tok_req  = s_axis_tdata[TOK_LSB +: TOK_W];
  assign w_tok_gnt  = (w_tok_req > GNT_MAX) ? GNT_MAX : w_tok_req;
  assign w_grant    = w_req_conn && (w_tok_req != '0);
  assign w_id_ok    = {1'b0, w_req_id} < ID_LIMIT;

  assign w_unused_bits = ^{s_axis_tdata[7:5], s_axis_tdata[15:14],
                           s_axis_tdata[AXIS_DATA_WIDTH-1:24]};

  // Look up the state of the requested entry and of the pending entry.
  // NOTE: every signal gets a default before the loop so no latch is inferred.
  always_comb begin
    w_req_state  = ENTRY_IDLE;
    w_pend_state = ENTRY_IDLE;
    w_pend_busy  = 1'b0;
    for (int i = 0; i < TBU_NUM; i++) begin
      if (w_req_id == TBU_NUM_WIDTH'(i)) w_req_state = w_state[i];
      if (r_pend_id == TBU_NUM_WIDTH'(i)) begin
        w_pend_state = w_state[i];
        w_pend_busy  = tbu_busy[i];
      end
    end
  end

  assign w_legal = (w_msg_type == DTI_TBU_CONDIS_REQ) && w_id_ok &&
                   (w_req_conn ? (w_req_state == ENTRY_IDLE)
                               : ((w_req_state == ENTRY_CONNECTED) ||
                                  (w_req_state == ENTRY_TRANSACTION)));

  assign s_axis_tready = !r_pending;
  assign w_accept      = s_axis_tvalid && !r_pending;
  assign w_ack_hs      = r_mvalid && m_axis_tready;

  // Request/ack sequencing: one request in flight, ack held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_pend_disc  <= 1'b0;
      r_pend_grant <= 1'b0;
      r_pend_id    <= '0;
      r_mvalid     <= 1'b0;
      r_mdata      <= '0;
    end else if (w_accept && w_legal) begin
      r_pending    <= 1'b1;
      r_pend_disc  <= !w_req_conn;
      r_pend_grant <= w_grant;
      r_pend_id    <= w_req_id;
      if (w_req_conn) begin
        r_mvalid <= 1'b1;
        r_mdata  <= make_ack(w_grant, w_req_id, w_grant ? w_tok_gnt : '0);
      end
    end else if (r_pending && r_pend_disc && !r_mvalid &&
                 (w_pend_state == ENTRY_DISCONNECTED) && !w_pend_busy) begin
      r_mvalid <= 1'b1;
      r_mdata  <= make_ack(1'b0, r_pend_id, '0);
    end else if (w_ack_hs) begin
      r_mvalid  <= 1'b0;
      r_pending <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_mvalid;
  assign m_axis_tdata  = r_mdata;

  for (genvar g = 0; g < TBU_NUM; g++) begin : g_entry
    localparam logic [TBU_NUM_WIDTH-1:0] ID = TBU_NUM_WIDTH'(g);
    dti_condis_entry u_entry (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_busy           (tbu_busy[g]),
      .i_disconnect     (w_accept && w_legal && !w_req_conn && (w_req_id == ID)),
      .i_ack_connect    (w_ack_hs && r_pend_grant && !r_pend_disc && (r_pend_id == ID)),
      .i_ack_disconnect (w_ack_hs && r_pend_disc && (r_pend_id == ID)),
      .o_state          (w_state[g]),
      .o_connected      (tbu_connected[g])
    );
  end

`ifdef DTI_CONDIS_ERR_EN
  logic       r_err_pulse;
  logic [7:0] r_err_cnt;

  // Pulse and saturating count for each dropped illegal request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: doc/dti_condis_responder.md
DTI_CONDIS_RESPONDER -- requirements
Module: dti_condis_responder

Interface
REQ-001 SHALL have parameter TBU_NUM, default 2, number of TBU entries tracked (≤ 2^TBU_NUM_WIDTH).
REQ-002 SHALL have parameter TOK_GNT_MAX, default 8, maximum translation tokens granted per connect.
REQ-003 SHALL have one clock and one asynchronous active-low reset: clk  input  1  clock; rst_n  input  1  async reset, active low.
REQ-004 SHALL have s_axis_tvalid  input  1  request valid from TBU side.
REQ-005 SHALL have s_axis_tready  output  1  request accepted.
REQ-006 SHALL have s_axis_tdata  input  AXIS_DATA_WIDTH  request message.
REQ-007 SHALL have m_axis_tvalid  output  1  ack valid.
REQ-008 SHALL have m_axis_tready  input  1  ack consumed.
REQ-009 SHALL have m_axis_tdata  output  AXIS_DATA_WIDTH  ack message.
REQ-010 SHALL have tbu_busy  input  TBU_NUM  per-TBU outstanding-translation flag.
REQ-011 SHALL have tbu_connected  output  TBU_NUM  entry is CONNECTED or TRANSACTION.

Function
REQ-012 SHALL decode request fields: [3:0] msg_type, [4] state (1 = connect, 0 = disconnect), [13:8] tbu_id, [23:16] tok_trans_req; all other bits ignored.
REQ-013 SHALL encode ack fields: [3:0] = DTI_TBU_CONDIS_ACK, [4] = granted state, [13:8] = tbu_id, [23:16] = tok_trans_gnt; all other bits 0.
REQ-014 SHALL drive s_axis_tready = 1 only when no request is pending; exactly one request in flight.
REQ-015 SHALL, for a legal connect to an IDLE entry with tok_trans_req > 0, assert m_axis_tvalid the cycle after acceptance, with state = 1 and tok_trans_gnt = min(tok_trans_req, TOK_GNT_MAX).
REQ-016 SHALL, for a connect with tok_trans_req = 0, ack with state = 0 and tok_trans_gnt = 0; the entry stays IDLE.
REQ-017 SHALL, on acceptance of a disconnect to a CONNECTED or TRANSACTION entry, move the entry to DISCONNECTED.
REQ-018 SHALL ack a disconnect (state = 0, tok_trans_gnt = 0) the cycle after tbu_busy[id] is sampled low while the entry is DISCONNECTED; it waits indefinitely while busy is high.
REQ-019 SHALL hold m_axis_tvalid and m_axis_tdata stable until m_axis_tready = 1.
REQ-020 SHALL, on the ack handshake, move the entry IDLE→CONNECTED (connect granted) or DISCONNECTED→IDLE, clear pending, and raise s_axis_tready the next cycle.
REQ-021 SHALL move CONNECTED→TRANSACTION when tbu_busy[i] = 1, and TRANSACTION→CONNECTED when tbu_busy[i] = 0, evaluated every cycle; DISCONNECTED and IDLE entries ignore tbu_busy.
REQ-022 SHALL treat a request as illegal when any of these holds: msg_type ≠ DTI_TBU_CONDIS_REQ, tbu_id ≥ TBU_NUM, connect to a non-IDLE entry, or disconnect to an IDLE or DISCONNECTED entry.
REQ-023 SHALL consume an illegal request in one cycle, send no ack, and leave all entry states unchanged.
REQ-024 SHALL update entries other than the pending one independently of the handshake.

Reset
REQ-025 SHALL on rst_n = 0 set all entries IDLE, m_axis_tvalid = 0, m_axis_tdata = 0, tbu_connected = 0, pending = 0, and s_axis_tready = 1 from the first cycle after reset release.
REQ-026 SHALL abandon any pending request or ack on reset mid-operation; no ack is emitted after reset.

Configuration
REQ-027 SHALL, with DTI_CONDIS_ERR_EN defined, add output err_pulse (1, one-cycle pulse per illegal request) and err_cnt (8, saturating at 255, reset 0).
REQ-028 SHALL, without DTI_CONDIS_ERR_EN, omit both ports and the associated logic; illegal requests are still dropped per REQ-023.

Structure
REQ-029 SHALL import entry_state_t, m_msg_type_t, s_msg_type_t, AXIS_DATA_WIDTH, TBU_NUM_WIDTH from dti_pack; field bit-position localparams SHALL be added to dti_pack.
REQ-030 SHALL instantiate sub-module dti_condis_entry (per-TBU entry_state_t FSM) TBU_NUM times.

Verification
REQ-031 Connect tbu_id = 1, tok_trans_req = 12, m_axis_tready = 1 -> ack next cycle with [4] = 1, gnt = 8, tbu_connected = 2'b10.
REQ-032 Entry 0 connected, tbu_busy[0] = 1, disconnect id 0, busy held for 5 cycles -> no ack for 5 cycles, ack state = 0 one cycle after busy falls, entry 0 IDLE.
REQ-033 Legal connect with m_axis_tready = 0 for 4 cycles -> tvalid/tdata stable, s_axis_tready = 0, second request stalls until handshake.
REQ-034 tbu_id = 5 (TBU_NUM = 2), msg_type = 4'h3, or disconnect to IDLE -> no ack, states unchanged; with DTI_CONDIS_ERR_EN, err_cnt = 3.
REQ-035 Connect with tok_trans_req = 0 -> ack state = 0, gnt = 0, tbu_connected stays 0.
REQ-036 Assert rst_n = 0 while an ack is waiting -> m_axis_tvalid = 0 immediately, all entries IDLE, s_axis_tready = 1 after release.
